key_event_decoder: RTL and testbench

Sits directly downstream of the key debouncer and consumes its clean, synchronous key level. It classifies key activity into single-cycle event pulses: press, release, short click, double click, long press and auto-repeat. These pulses feed the AE350 demo GPIO/interrupt logic, so software never times keys itself.

---
 rtl/key_event_decoder.sv | 192 +++++++++++++++++++
 tb/tb_key_event_decoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
// key_event_decoder
// Turns the debounced, clock-synchronous key level into single-cycle event
// pulses: press, release, short click, double click, long press and
// auto-repeat. Every output is registered; an input edge sampled on clock
// edge N produces its pulse (and any state change) in the cycle after N.
module key_event_decoder #(
    parameter int ACTIVE_LOW = 1,
    parameter int LONG_CNT   = 50000000,
    parameter int REPEAT_CNT = 10000000,
    parameter int DCLICK_CNT = 15000000,
    parameter int DCLICK_EN  = 1,
    parameter int CNT_W      = 26
) (
    input  logic clk,
    input  logic rstn,
    input  logic key_level,
    output logic key_held,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_click,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRESS1 = 3'd1,
        S_LONG   = 3'd2,
        S_WAIT2  = 3'd3,
        S_PRESS2 = 3'd4
    } state_t;

    // Polarity of the "pressed" level and the last timer value of each phase.
    localparam logic             ACT_LVL     = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic             DCLK_ON     = (DCLICK_EN != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);
    localparam logic [CNT_W-1:0] DCLK_LAST   = CNT_W'(DCLICK_CNT - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_next_timer;
    logic             r_prev_pressed;

    logic             r_press_pulse;
    logic             r_release_pulse;
    logic             r_short_click;
    logic             r_double_click;
    logic             r_long_press;
    logic             r_repeat_pulse;

    logic             w_pressed;
    logic             w_press_edge;
    logic             w_release_edge;
    logic             w_timer_clr;
    logic             w_short;
    logic             w_double;
    logic             w_long;
    logic             w_repeat;

    // A held key in either polarity becomes a plain active-high "pressed".
    assign w_pressed      = key_level ^ ACT_LVL;
    assign w_press_edge   = w_pressed & ~r_prev_pressed;
    assign w_release_edge = ~w_pressed & r_prev_pressed;

    // Previous pressed state; resets to not-pressed so a key held through
    // reset is reported as a fresh press.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_prev_pressed <= 1'b0;
        end else begin
            r_prev_pressed <= w_pressed;
        end
    end

    // Next-state and click classification. Release edges are checked before
    // the long/repeat thresholds so a release on the threshold cycle wins,
    // and a second press wins over the double-click timeout.
    always_comb begin
        w_next_state = r_state;
        w_timer_clr  = 1'b0;
        w_short      = 1'b0;
        w_double     = 1'b0;
        w_long       = 1'b0;
        w_repeat     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_press_edge) begin
                    w_next_state = S_PRESS1;
                end
            end

            S_PRESS1: begin
                if (w_release_edge) begin
                    if (DCLK_ON) begin
                        w_next_state = S_WAIT2;
                    end else begin
                        w_next_state = S_IDLE;
                        w_short      = 1'b1;
                    end
                end else if (r_timer == LONG_LAST) begin
                    w_next_state = S_LONG;
                    w_long       = 1'b1;
                end
            end

            S_LONG: begin
                if (w_release_edge) begin
                    w_next_state = S_IDLE;
                end else if (r_timer == REPEAT_LAST) begin
                    w_repeat    = 1'b1;
                    w_timer_clr = 1'b1;
                end
            end

            S_WAIT2: begin
                if (w_press_edge) begin
                    w_next_state = S_PRESS2;
                end else if (r_timer == DCLK_LAST) begin
                    w_next_state = S_IDLE;
                    w_short      = 1'b1;
                end
            end

            S_PRESS2: begin
                if (w_release_edge) begin
                    w_next_state = S_IDLE;
                    w_double     = 1'b1;
                end else if (r_timer == LONG_LAST) begin
                    // Held too long: the pending first click is dropped.
                    w_next_state = S_LONG;
                    w_long       = 1'b1;
                end
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Timer restarts on every state change or repeat; it idles at zero in
    // IDLE so it can never wrap while waiting for a key.
    always_comb begin
        w_next_timer = r_timer + 1'b1;
        if ((w_next_state != r_state) || w_timer_clr || (r_state == S_IDLE)) begin
            w_next_timer = '0;
        end
    end

    // State and phase timer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_next_state;
            r_timer <= w_next_timer;
        end
    end

    // Registered event pulses, each high for the single cycle after its cause.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_short_click   <= 1'b0;
            r_double_click  <= 1'b0;
            r_long_press    <= 1'b0;
            r_repeat_pulse  <= 1'b0;
        end else begin
            r_press_pulse   <= w_press_edge;
            r_release_pulse <= w_release_edge;
            r_short_click   <= w_short;
            r_double_click  <= w_double;
            r_long_press    <= w_long;
            r_repeat_pulse  <= w_repeat;
        end
    end

    assign key_held      = r_prev_pressed;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
    assign short_click   = r_short_click;
    assign double_click  = r_double_click;
    assign long_press    = r_long_press;
    assign repeat_pulse  = r_repeat_pulse;

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: two instances (double-click enabled and
// disabled) share clock, reset and key. A timestamp-based event model
// predicts all outputs every cycle; directed scenarios also check event
// counts and click latency.
module tb_key_event_decoder;

    localparam int LONG_C = 20;
    localparam int REP_C  = 5;
    localparam int DCLK_C = 10;

    logic clk;
    logic rstn;
    logic key_level;
    logic key;          // active-high "pressed" view driven by the bench

    logic [6:0] o_dut [2];
    logic o_held   [2];
    logic o_press  [2];
    logic o_rel    [2];
    logic o_short  [2];
    logic o_dbl    [2];
    logic o_long   [2];
    logic o_rep    [2];

    key_event_decoder #(
        .ACTIVE_LOW(1), .LONG_CNT(LONG_C), .REPEAT_CNT(REP_C),
        .DCLICK_CNT(DCLK_C), .DCLICK_EN(1), .CNT_W(8)
    ) u_dut0 (
        .clk(clk), .rstn(rstn), .key_level(key_level),
        .key_held(o_held[0]), .press_pulse(o_press[0]), .release_pulse(o_rel[0]),
        .short_click(o_short[0]), .double_click(o_dbl[0]),
        .long_press(o_long[0]), .repeat_pulse(o_rep[0])
    );

    key_event_decoder #(
        .ACTIVE_LOW(1), .LONG_CNT(LONG_C), .REPEAT_CNT(REP_C),
        .DCLICK_CNT(DCLK_C), .DCLICK_EN(0), .CNT_W(8)
    ) u_dut1 (
        .clk(clk), .rstn(rstn), .key_level(key_level),
        .key_held(o_held[1]), .press_pulse(o_press[1]), .release_pulse(o_rel[1]),
        .short_click(o_short[1]), .double_click(o_dbl[1]),
        .long_press(o_long[1]), .repeat_pulse(o_rep[1])
    );

    always_comb begin
        for (int m = 0; m < 2; m++) begin
            o_dut[m] = {o_held[m], o_press[m], o_rel[m], o_short[m],
                        o_dbl[m], o_long[m], o_rep[m]};
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: per instance, remembers when the current press began,
    // when the last unclaimed short release happened, and whether the press
    // has already been promoted to a long press.
    bit         m_pp   [2];
    bit         m_pend [2];
    bit         m_sec  [2];
    bit         m_lng  [2];
    int         m_pt   [2];
    int         m_rt   [2];
    logic [6:0] m_exp  [2];
    int         t_edge = 0;

    task automatic model_step(input int m, input bit p, input bit rst_ok);
        bit pe, re, s, d, l, r;
        int age;
        bit en;
        en = (m == 0);
        s = 0; d = 0; l = 0; r = 0;
        if (!rst_ok) begin
            m_pp[m] = 0; m_pend[m] = 0; m_sec[m] = 0; m_lng[m] = 0;
            m_exp[m] = '0;
            return;
        end
        pe = p && !m_pp[m];
        re = !p && m_pp[m];
        if (pe) begin
            m_sec[m]  = m_pend[m];
            m_pend[m] = 0;
            m_pt[m]   = t_edge;
            m_lng[m]  = 0;
        end else if (re) begin
            if (!m_lng[m]) begin
                if (!en)           s = 1;
                else if (m_sec[m]) d = 1;
                else begin
                    m_pend[m] = 1;
                    m_rt[m]   = t_edge;
                end
            end
            m_sec[m] = 0;
            m_lng[m] = 0;
        end else if (p) begin
            age = t_edge - m_pt[m];
            if (!m_lng[m] && age == LONG_C) begin
                l = 1; m_lng[m] = 1; m_sec[m] = 0;
            end else if (m_lng[m] && age > LONG_C && ((age - LONG_C) % REP_C) == 0) begin
                r = 1;
            end
        end else if (m_pend[m] && (t_edge - m_rt[m]) == DCLK_C) begin
            s = 1;
            m_pend[m] = 0;
        end
        m_pp[m]  = p;
        m_exp[m] = {p, pe, re, s, d, l, r};
    endtask

    int cyc_n = 0;
    int cnt [2][7];
    int rel_cyc, short_cyc;

    task automatic clr_counts();
        for (int m = 0; m < 2; m++)
            for (int b = 0; b < 7; b++) cnt[m][b] = 0;
        rel_cyc = -1; short_cyc = -1;
    endtask

    // One clock: model follows the sampled inputs, outputs compared mid-cycle.
    task automatic cyc();
        @(posedge clk);
        t_edge++;
        for (int m = 0; m < 2; m++) model_step(m, key, rstn);
        @(negedge clk);
        cyc_n++;
        check("outs_dclk_on",  {25'd0, o_dut[0]}, {25'd0, m_exp[0]});
        check("outs_dclk_off", {25'd0, o_dut[1]}, {25'd0, m_exp[1]});
        for (int m = 0; m < 2; m++)
            for (int b = 0; b < 6; b++)
                if (o_dut[m][b]) cnt[m][b]++;
        if (o_dut[0][4]) rel_cyc = cyc_n;
        if (o_dut[0][3]) short_cyc = cyc_n;
    endtask

    task automatic hold(input int n, input bit v);
        for (int i = 0; i < n; i++) begin
            key = v;
            key_level = ~v;
            cyc();
        end
    endtask

    task automatic do_reset(input int n);
        rstn = 1'b0;
        #1;
        check("async_rst_on",  {25'd0, o_dut[0][5:0]}, 32'd0);
        check("async_rst_off", {25'd0, o_dut[1][5:0]}, 32'd0);
        for (int i = 0; i < n; i++) cyc();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Count index map: 6 held, 5 press, 4 release, 3 short, 2 double, 1 long, 0 repeat.
    initial begin
        rstn = 1'b0;
        key = 1'b0;
        key_level = 1'b1;
        clr_counts();
        for (int i = 0; i < 3; i++) cyc();
        check("reset_state", {25'd0, o_dut[0]}, 32'd0);
        rstn = 1'b1;
        hold(3, 0);

        // Short click: confirmed 10 cycles after the release pulse.
        clr_counts();
        hold(8, 1); hold(15, 0);
        check("sc_press",   cnt[0][5], 1);
        check("sc_release", cnt[0][4], 1);
        check("sc_short",   cnt[0][3], 1);
        check("sc_latency", short_cyc - rel_cyc, DCLK_C);
        check("sc_other",   cnt[0][2] + cnt[0][1] + cnt[0][0], 0);

        // Double click.
        clr_counts();
        hold(5, 1); hold(4, 0); hold(5, 1); hold(14, 0);
        check("dc_double", cnt[0][2], 1);
        check("dc_short",  cnt[0][3], 0);
        check("dc_press",  cnt[0][5], 2);
        check("dc_rel",    cnt[0][4], 2);
        check("dc_nodc_short", cnt[1][3], 2);

        // Long press with repeats.
        clr_counts();
        hold(37, 1); hold(14, 0);
        check("lp_long",  cnt[0][1], 1);
        check("lp_rep",   cnt[0][0], 3);
        check("lp_click", cnt[0][3] + cnt[0][2], 0);
        check("lp_rel",   cnt[0][4], 1);

        // Release exactly on the long threshold: no long press, later a short click.
        clr_counts();
        hold(LONG_C, 1); hold(14, 0);
        check("rt_long",  cnt[0][1], 0);
        check("rt_short", cnt[0][3], 1);

        // Second press on the timeout cycle wins, then becomes a long press.
        clr_counts();
        hold(3, 1); hold(DCLK_C, 0); hold(LONG_C + 2, 1); hold(14, 0);
        check("to_short",  cnt[0][3], 0);
        check("to_double", cnt[0][2], 0);
        check("to_long",   cnt[0][1], 1);

        // Reset while in LONG with the key held.
        clr_counts();
        hold(LONG_C + 3, 1);
        key = 1'b1; key_level = 1'b0;
        do_reset(3);
        clr_counts();
        hold(1, 1);
        check("rr_press", {31'd0, o_press[0]}, 32'd1);
        hold(4, 1); hold(14, 0);
        check("rr_nodc_short", cnt[1][3], 1);
        check("rr_dc_short",   cnt[0][3], 1);

        // Randomized key activity, with the occasional reset.
        for (int e = 0; e < 60; e++) begin
            int r_sel;
            hold($urandom_range(1, 45), 1);
            r_sel = $urandom_range(0, 3);
            if (r_sel == 0)      hold(DCLK_C, 0);
            else if (r_sel == 1) hold(DCLK_C - 1, 0);
            else                 hold($urandom_range(1, 16), 0);
            if ($urandom_range(0, 15) == 0) do_reset($urandom_range(1, 3));
        end
        hold(20, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
